// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time over valid/ready,
// byte/half stores by read-modify-write, loads returned lane-extracted and extended.
module dmem_responder #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, RD, MRG, RSP} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        mem_q, mem_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        mem_array [DEPTH];
    logic               mem_we;
    logic [31:0]        merged;
    logic [31:0]        load_val;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic               req_bad;
    logic [IDX_W-1:0]   idx;

    assign idx       = addr_q[IDX_W+1:2];
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        req_bad = 1'b0;
        if (req_size == 2'b11)                               req_bad = 1'b1;
        if (req_size == 2'b01 && req_addr[0])                req_bad = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)     req_bad = 1'b1;
        if (req_addr[31:2] >= 30'(DEPTH))                    req_bad = 1'b1;
    end

    // Lane extraction and extension for loads.
    always_comb begin
        lane_b = mem_q[7:0];
        case (addr_q[1:0])
            2'd0: lane_b = mem_q[7:0];
            2'd1: lane_b = mem_q[15:8];
            2'd2: lane_b = mem_q[23:16];
            2'd3: lane_b = mem_q[31:24];
            default: lane_b = mem_q[7:0];
        endcase
        lane_h = addr_q[1] ? mem_q[31:16] : mem_q[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mem_q;
        endcase
    end

    // Store merge: only the addressed lane is replaced.
    always_comb begin
        merged = mem_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged[7:0]   = wdata_q[7:0];
                    2'd1: merged[15:8]  = wdata_q[7:0];
                    2'd2: merged[23:16] = wdata_q[7:0];
                    2'd3: merged[31:24] = wdata_q[7:0];
                    default: merged = mem_q;
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        mem_d       = mem_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[IDX_W+1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        state_d     = RSP;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_d   = mem_array[idx];
                state_d = MRG;
            end
            MRG: begin
                // Write happens on the edge leaving MRG, so a reset before then drops the store.
                if (we_q) begin
                    mem_we      = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else begin
                    rsp_rdata_d = load_val;
                end
                rsp_err_d = 1'b0;
                state_d   = RSP;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0;
            mem_q       <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            mem_q       <= mem_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The array itself carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_array[idx] <= merged;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-addressed memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned mb [16384];
    bit           wr [16384];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(4096), .IDX_W(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_bad(input logic [31:0] addr, input logic [1:0] size);
        int n;
        if (size == 2'b11) return 1'b1;
        n = 1 << size;
        if ((addr % n) != 0) return 1'b1;
        return addr >= 32'd16384;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[addr + i]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
        return v;
    endfunction

    function automatic bit model_known(input logic [31:0] addr, input logic [1:0] size);
        for (int i = 0; i < (1 << size); i++) if (!wr[addr + i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [1:0] size,
                                        input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) begin
            mb[addr + i] = 8'((wdata >> (8 * i)) & 32'hff);
            wr[addr + i] = 1'b1;
        end
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input string tag);
        bit          bad;
        bit          known;
        logic [31:0] exp;
        int          lat;
        bad   = model_bad(addr, size);
        known = 1'b1;
        exp   = 32'h0;
        if (!we && !bad) begin
            known = model_known(addr, size);
            exp   = model_load(addr, size, uns);
        end
        @(negedge clk);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk({tag, " latency"}, 32'(lat), bad ? 32'd1 : 32'd3);
        chk({tag, " err"}, 32'(rsp_err), 32'(bad));
        if (known) chk({tag, " rdata"}, rsp_rdata, exp);
        if (we && !bad) model_store(addr, size, wdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] a;
        logic [1:0]  s;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        do_req(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, "st_w");
        do_req(0, 32'h10, 2'b10, 0, 32'h0, "ld_w");
        chk("ld_w value", model_load(32'h10, 2'b10, 0), 32'hDEADBEEF);

        do_req(1, 32'h10, 2'b10, 0, 32'h11223344, "st_w2");
        do_req(1, 32'h13, 2'b00, 0, 32'h00000080, "st_b");
        do_req(0, 32'h10, 2'b10, 0, 32'h0, "ld_w_after_b");
        do_req(0, 32'h13, 2'b00, 0, 32'h0, "ld_b_s");
        do_req(0, 32'h13, 2'b00, 1, 32'h0, "ld_b_u");

        do_req(1, 32'h10, 2'b10, 0, 32'h11223344, "st_w3");
        do_req(1, 32'h12, 2'b01, 0, 32'h0000BEEF, "st_h");
        do_req(0, 32'h10, 2'b10, 0, 32'h0, "ld_w_after_h");
        do_req(0, 32'h12, 2'b01, 0, 32'h0, "ld_h_s");
        do_req(0, 32'h12, 2'b01, 1, 32'h0, "ld_h_u");

        do_req(0, 32'h6,    2'b10, 0, 32'h0,      "bad_w_mis");
        do_req(1, 32'h11,   2'b01, 0, 32'hFFFF,   "bad_h_mis");
        do_req(0, 32'h10,   2'b10, 0, 32'h0,      "ld_after_bad");
        do_req(0, 32'h4000, 2'b10, 0, 32'h0,      "bad_range");
        do_req(0, 32'h10,   2'b11, 0, 32'h0,      "bad_size");

        // Backpressure: response held for 5 cycles with a new request waiting.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h12; req_size = 2'b01; req_unsigned = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("bp latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp rsp_rdata", rsp_rdata, model_load(32'h10, 2'b10, 0));
            chk("bp req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp post rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp post req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("bp next latency", 32'(lat), 32'd3);
        chk("bp next rdata", rsp_rdata, model_load(32'h12, 2'b01, 1));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset during RD of a store: the store must be dropped.
        do_req(1, 32'h20, 2'b10, 0, 32'h0, "st_zero");
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 32'h20, 2'b10, 0, 32'h0, "ld_after_rst");

        // Random traffic over a small window plus occasional out-of-range addresses.
        for (int w = 0; w < 16; w++) do_req(1, 32'(w * 4), 2'b10, 0, $urandom, "rnd_init");
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'h4000 + $urandom_range(0, 32'h3FFF);
            else                            a = $urandom_range(0, 63);
            s = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), a, s, 1'($urandom), $urandom, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
